// File: rtl/id_ex_ctl_pkg.sv
// Shared constants and types for the pipeline stage registers of the 5-stage core.
package id_ex_ctl_pkg;

  // Default bus widths used across the pipeline
  localparam int AluOpBusW  = 8;
  localparam int AluSelBusW = 3;
  localparam int RegBusW    = 32;
  localparam int RegAddrBusW = 5;
  localparam int StallBusW  = 6;
  localparam int BubbleCntW = 16;

  // Stall vector bit positions driven by the central stall controller
  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;

  // NOP-pattern values loaded on reset, flush and bubble
  localparam int   EXE_NOP_OP   = 0;
  localparam int   EXE_RES_NOP  = 0;
  localparam int   ZeroWord     = 0;
  localparam int   NOPRegAddr   = 0;
  localparam logic WriteDisable = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic RstEnable    = 1'b1;

  // Action a pipeline stage register takes in a given cycle
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_CLEAR  = 2'd3
  } stage_act_e;

  // One-hot view of the same action, convenient for register enables
  typedef struct packed {
    logic load;
    logic hold;
    logic bubble;
    logic clear;
  } stage_ctl_t;

  // Expand an action code into its one-hot control word
  function automatic stage_ctl_t act_to_ctl(input stage_act_e act);
    stage_ctl_t ctl;
    ctl = '0;
    case (act)
      ACT_LOAD:   ctl.load   = 1'b1;
      ACT_HOLD:   ctl.hold   = 1'b1;
      ACT_BUBBLE: ctl.bubble = 1'b1;
      default:    ctl.clear  = 1'b1;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/id_ex_ctl_pipe_stage_ctl.sv
// Decodes the stall vector and flush into a one-hot stage action.
// Shared by every stage register (if_id, id_ex, ex_mem, mem_wb).
module pipe_stage_ctl
  import id_ex_ctl_pkg::*;
#(
  parameter int STALL_W = StallBusW
) (
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  output stage_act_e         o_act,
  output stage_ctl_t         o_ctl
);

  logic w_stall_id;
  logic w_stall_ex;
  logic w_unused_stall;

  assign w_stall_id     = stall[STALL_ID];
  assign w_stall_ex     = stall[STALL_EX];
  // Only the ID and EX bits matter for this stage; the rest are don't-cares
  assign w_unused_stall = ^stall;

  // Priority decode: flush beats bubble beats hold; an EX stall without an ID stall is treated as hold
  always_comb begin
    o_act = ACT_LOAD;
    if (flush) begin
      o_act = ACT_CLEAR;
    end else if (w_stall_id && !w_stall_ex) begin
      o_act = ACT_BUBBLE;
    end else if (w_stall_ex) begin
      o_act = ACT_HOLD;
    end else begin
      o_act = ACT_LOAD;
    end
  end

  assign o_ctl = act_to_ctl(o_act);

endmodule

// File: rtl/id_ex_ctl.sv
// ID/EX pipeline register with hold, bubble, flush, valid tracking,
// delay-slot feedback and a saturating bubble counter.
module id_ex_ctl
  import id_ex_ctl_pkg::*;
#(
  parameter int ALUOP_W  = AluOpBusW,
  parameter int ALUSEL_W = AluSelBusW,
  parameter int DATA_W   = RegBusW,
  parameter int RADDR_W  = RegAddrBusW,
  parameter int STALL_W  = StallBusW,
  parameter int CNT_W    = BubbleCntW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                cnt_clr,
  input  logic                id_valid,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [RADDR_W-1:0]  id_wd,
  input  logic                id_wreg,
  input  logic [DATA_W-1:0]   id_link_addr,
  input  logic                id_is_in_delayslot,
  input  logic                next_inst_in_delayslot_i,
  output logic                ex_valid,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [RADDR_W-1:0]  ex_wd,
  output logic                ex_wreg,
  output logic [DATA_W-1:0]   ex_link_addr,
  output logic                ex_is_in_delayslot,
  output logic                is_in_delayslot_o,
  output logic [CNT_W-1:0]    bubble_cnt
);

  stage_act_e w_act;
  stage_ctl_t w_ctl;
  logic       w_nop_load;

  logic                r_valid;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [RADDR_W-1:0]  r_wd;
  logic                r_wreg;
  logic [DATA_W-1:0]   r_link_addr;
  logic                r_ex_delayslot;
  logic                r_delayslot_fb;
  logic [CNT_W-1:0]    r_bubble_cnt;

  pipe_stage_ctl #(
    .STALL_W (STALL_W)
  ) u_stage_ctl (
    .stall (stall),
    .flush (flush),
    .o_act (w_act),
    .o_ctl (w_ctl)
  );

  // Flush and bubble both replace the EX contents with the NOP pattern
  assign w_nop_load = w_ctl.clear | w_ctl.bubble;

  // EX-side datapath register: NOP on flush/bubble, capture on load, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_valid        <= 1'b0;
      r_aluop        <= ALUOP_W'(EXE_NOP_OP);
      r_alusel       <= ALUSEL_W'(EXE_RES_NOP);
      r_reg1         <= DATA_W'(ZeroWord);
      r_reg2         <= DATA_W'(ZeroWord);
      r_wd           <= RADDR_W'(NOPRegAddr);
      r_wreg         <= WriteDisable;
      r_link_addr    <= DATA_W'(ZeroWord);
      r_ex_delayslot <= 1'b0;
    end else if (w_nop_load) begin
      r_valid        <= 1'b0;
      r_aluop        <= ALUOP_W'(EXE_NOP_OP);
      r_alusel       <= ALUSEL_W'(EXE_RES_NOP);
      r_reg1         <= DATA_W'(ZeroWord);
      r_reg2         <= DATA_W'(ZeroWord);
      r_wd           <= RADDR_W'(NOPRegAddr);
      r_wreg         <= WriteDisable;
      r_link_addr    <= DATA_W'(ZeroWord);
      r_ex_delayslot <= 1'b0;
    end else if (w_ctl.load) begin
      r_valid        <= id_valid;
      r_aluop        <= id_aluop;
      r_alusel       <= id_alusel;
      r_reg1         <= id_reg1;
      r_reg2         <= id_reg2;
      r_wd           <= id_wd;
      r_wreg         <= id_wreg;
      r_link_addr    <= id_link_addr;
      r_ex_delayslot <= id_is_in_delayslot;
    end
  end

  // Delay-slot flag returned to ID: cleared by flush, kept through bubbles and holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_delayslot_fb <= 1'b0;
    end else if (w_ctl.clear) begin
      r_delayslot_fb <= 1'b0;
    end else if (w_ctl.load) begin
      r_delayslot_fb <= next_inst_in_delayslot_i;
    end
  end

  // Saturating bubble counter; an explicit clear wins over a same-cycle bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_bubble_cnt <= '0;
    end else if (w_ctl.bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid           = r_valid;
  assign ex_aluop           = r_aluop;
  assign ex_alusel          = r_alusel;
  assign ex_reg1            = r_reg1;
  assign ex_reg2            = r_reg2;
  assign ex_wd              = r_wd;
  assign ex_wreg            = r_wreg;
  assign ex_link_addr       = r_link_addr;
  assign ex_is_in_delayslot = r_ex_delayslot;
  assign is_in_delayslot_o  = r_delayslot_fb;
  assign bubble_cnt         = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_ctl.sv
// Directed bench for id_ex_ctl: a default-width instance plus a CNT_W=4 instance for saturation.
module tb_id_ex_ctl;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cnt_clr;
  logic        id_valid;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1;
  logic [31:0] id_reg2;
  logic [4:0]  id_wd;
  logic        id_wreg;
  logic [31:0] id_link_addr;
  logic        id_is_in_delayslot;
  logic        next_ds;

  logic        ex_valid;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_link_addr;
  logic        ex_is_in_delayslot;
  logic        ds_o;
  logic [15:0] bubble_cnt;

  logic [5:0]  stall2;
  logic        cnt_clr2;
  logic        s_valid;
  logic [7:0]  s_aluop;
  logic [2:0]  s_alusel;
  logic [31:0] s_reg1;
  logic [31:0] s_reg2;
  logic [4:0]  s_wd;
  logic        s_wreg;
  logic [31:0] s_link;
  logic        s_exds;
  logic        s_ds;
  logic [3:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_ctl dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .id_link_addr(id_link_addr), .id_is_in_delayslot(id_is_in_delayslot),
    .next_inst_in_delayslot_i(next_ds),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_link_addr(ex_link_addr), .ex_is_in_delayslot(ex_is_in_delayslot),
    .is_in_delayslot_o(ds_o), .bubble_cnt(bubble_cnt)
  );

  id_ex_ctl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall2), .flush(1'b0), .cnt_clr(cnt_clr2),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_alusel(id_alusel),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .id_link_addr(id_link_addr), .id_is_in_delayslot(id_is_in_delayslot),
    .next_inst_in_delayslot_i(next_ds),
    .ex_valid(s_valid), .ex_aluop(s_aluop), .ex_alusel(s_alusel),
    .ex_reg1(s_reg1), .ex_reg2(s_reg2), .ex_wd(s_wd), .ex_wreg(s_wreg),
    .ex_link_addr(s_link), .ex_is_in_delayslot(s_exds),
    .is_in_delayslot_o(s_ds), .bubble_cnt(s_cnt)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report tag/observed/expected if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Whole EX side equals the NOP pattern
  task automatic checkNop(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    checkOutput({tag, "_aluop"}, {24'd0, ex_aluop}, 32'd0);
    checkOutput({tag, "_reg1"}, ex_reg1, 32'd0);
    checkOutput({tag, "_wd"}, {27'd0, ex_wd}, 32'd0);
    checkOutput({tag, "_wreg"}, {31'd0, ex_wreg}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; flush = 1'b0; cnt_clr = 1'b0;
    stall2 = 6'd0; cnt_clr2 = 1'b0;
    id_valid = 1'b0; id_aluop = 8'd0; id_alusel = 3'd0; id_reg1 = 32'd0;
    id_reg2 = 32'd0; id_wd = 5'd0; id_wreg = 1'b0; id_link_addr = 32'd0;
    id_is_in_delayslot = 1'b0; next_ds = 1'b0;

    // Reset state
    applyStimulus(2);
    checkNop("reset");
    checkOutput("reset_ds", {31'd0, ds_o}, 32'd0);
    checkOutput("reset_cnt", {16'd0, bubble_cnt}, 32'd0);
    rst = 1'b0;

    // Plain load, one-cycle latency
    id_valid = 1'b1; id_aluop = 8'h21; id_alusel = 3'd3; id_reg1 = 32'hDEADBEEF;
    id_reg2 = 32'h0000_0055; id_wd = 5'd9; id_wreg = 1'b1; id_link_addr = 32'h100;
    id_is_in_delayslot = 1'b1; next_ds = 1'b1;
    applyStimulus(1);
    checkOutput("load_reg1", ex_reg1, 32'hDEADBEEF);
    checkOutput("load_reg2", ex_reg2, 32'h55);
    checkOutput("load_wd", {27'd0, ex_wd}, 32'd9);
    checkOutput("load_wreg", {31'd0, ex_wreg}, 32'd1);
    checkOutput("load_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("load_aluop", {24'd0, ex_aluop}, 32'h21);
    checkOutput("load_alusel", {29'd0, ex_alusel}, 32'd3);
    checkOutput("load_link", ex_link_addr, 32'h100);
    checkOutput("load_exds", {31'd0, ex_is_in_delayslot}, 32'd1);
    checkOutput("load_ds", {31'd0, ds_o}, 32'd1);

    // Asynchronous reset between edges clears outputs before the next edge
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_aluop", {24'd0, ex_aluop}, 32'd0);
    checkOutput("arst_wreg", {31'd0, ex_wreg}, 32'd0);
    checkOutput("arst_reg1", ex_reg1, 32'd0);
    checkOutput("arst_ds", {31'd0, ds_o}, 32'd0);
    #1 rst = 1'b0;

    // Delay slot flag set by a load, kept through a bubble
    id_reg1 = 32'hA5A5_0001; next_ds = 1'b1;
    applyStimulus(1);
    checkOutput("ds_set", {31'd0, ds_o}, 32'd1);
    checkOutput("ds_reg1", ex_reg1, 32'hA5A50001);
    stall = 6'b000111; next_ds = 1'b0;
    applyStimulus(1);
    checkOutput("ds_hold_bubble", {31'd0, ds_o}, 32'd1);
    checkNop("ds_bubble");
    checkOutput("ds_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);

    // Counter clear wins over a same-cycle bubble
    cnt_clr = 1'b1;
    applyStimulus(1);
    checkOutput("clr_vs_bubble", {16'd0, bubble_cnt}, 32'd0);
    cnt_clr = 1'b0;

    // Three bubble cycles: counter steps 1, 2, 3 and EX stays NOP
    for (int i = 1; i <= 3; i++) begin
      id_reg1 = 32'h1000 + i;
      applyStimulus(1);
      checkNop("bubble");
      checkOutput("bubble_cnt", {16'd0, bubble_cnt}, i);
    end

    // Load then hold for four cycles while ID keeps changing
    stall = 6'd0; id_reg1 = 32'h12345678; next_ds = 1'b0;
    applyStimulus(1);
    checkOutput("hold_load", ex_reg1, 32'h12345678);
    stall = 6'b001111;
    for (int i = 0; i < 4; i++) begin
      id_reg1 = 32'hCAFE_0000 + i; id_wd = 5'(i + 1); next_ds = 1'b1;
      applyStimulus(1);
      checkOutput("hold_reg1", ex_reg1, 32'h12345678);
      checkOutput("hold_wd", {27'd0, ex_wd}, 32'd9);
      checkOutput("hold_cnt", {16'd0, bubble_cnt}, 32'd3);
      checkOutput("hold_ds", {31'd0, ds_o}, 32'd0);
    end

    // EX stalled without ID stalled is a controller fault; stage must still hold
    $display("[TB] note: driving stall[3]=1 stall[2]=0, a stall-controller error condition");
    stall = 6'b001000; id_reg1 = 32'h0BAD_0BAD;
    applyStimulus(1);
    checkOutput("illegal_hold", ex_reg1, 32'h12345678);
    checkOutput("illegal_cnt", {16'd0, bubble_cnt}, 32'd3);

    // Flush overrides a simultaneous stall and clears the delay-slot flag
    stall = 6'd0; id_reg1 = 32'h7777_7777; next_ds = 1'b1;
    applyStimulus(1);
    checkOutput("pre_flush_ds", {31'd0, ds_o}, 32'd1);
    flush = 1'b1; stall = 6'b001111;
    applyStimulus(1);
    checkNop("flush");
    checkOutput("flush_ds", {31'd0, ds_o}, 32'd0);
    checkOutput("flush_cnt", {16'd0, bubble_cnt}, 32'd3);
    flush = 1'b0;

    // Flush together with a bubble does not count
    flush = 1'b1; stall = 6'b000100;
    applyStimulus(1);
    checkOutput("flush_bubble_cnt", {16'd0, bubble_cnt}, 32'd3);
    flush = 1'b0; stall = 6'd0;

    // Narrow counter saturates at 15 after 20 bubbles
    stall2 = 6'b110100;
    applyStimulus(14);
    checkOutput("sat_cnt14", {28'd0, s_cnt}, 32'd14);
    applyStimulus(6);
    checkOutput("sat_cnt", {28'd0, s_cnt}, 32'd15);
    checkOutput("sat_valid", {31'd0, s_valid}, 32'd0);
    cnt_clr2 = 1'b1;
    applyStimulus(1);
    checkOutput("sat_clr", {28'd0, s_cnt}, 32'd0);
    cnt_clr2 = 1'b0;
    applyStimulus(1);
    checkOutput("sat_restart", {28'd0, s_cnt}, 32'd1);
    checkOutput("main_cnt_idle", {16'd0, bubble_cnt}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
